// File: rtl/reg16_8_regfile_if.sv
// Register-file access bus: write port D plus two registered read ports A and B.
// The master side (decoder/ALU) drives the selects and write data; the slave side returns the read data.
interface reg16_8_regfile_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              en;
    logic              we;
    logic [DATA_W-1:0] data_d;
    logic [ADDR_W-1:0] sel_a;
    logic [ADDR_W-1:0] sel_b;
    logic [ADDR_W-1:0] sel_d;
    logic [DATA_W-1:0] data_out_a;
    logic [DATA_W-1:0] data_out_b;

    modport master (
        output en, we, data_d, sel_a, sel_b, sel_d,
        input  data_out_a, data_out_b
    );

    modport slave (
        input  en, we, data_d, sel_a, sel_b, sel_d,
        output data_out_a, data_out_b
    );
endinterface

// File: rtl/reg16_8_regfile.sv
// 8 x 16-bit general-purpose register file with two registered read ports and one write port.
// The global enable freezes all state so that the pipeline can stall.
module reg16_8_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    reg16_8_regfile_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] data_a_p1;
    logic [DATA_W-1:0] data_b_p1;

    // Reads sample the array before this edge's write lands, so there is no bypass path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            data_a_p1 <= '0;
            data_b_p1 <= '0;
        end else if (bus.en) begin
            if (bus.we) begin
                regs[bus.sel_d] <= bus.data_d;
            end
            data_a_p1 <= regs[bus.sel_a];
            data_b_p1 <= regs[bus.sel_b];
        end
    end

    assign bus.data_out_a = data_a_p1;
    assign bus.data_out_b = data_b_p1;
endmodule

// File: tb/tb_reg16_8_regfile.sv
// Scoreboard bench for reg16_8_regfile: a reference array predicts both read ports every edge.
module tb_reg16_8_regfile;
    logic clk;
    logic rst_n;

    reg16_8_regfile_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    reg16_8_regfile #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mdl [8];
    logic [15:0] held_a;
    logic [15:0] held_b;
    int          n_pass;
    int          n_total;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        held_a = 16'h0000;
        held_b = 16'h0000;
        sb_q.delete();
    endtask

    // Drive one cycle of stimulus, predict the outputs, then compare after the edge.
    task automatic cycle(input logic e, input logic w, input logic [2:0] sd, input logic [15:0] dd,
                         input logic [2:0] sa, input logic [2:0] sb, input string tag);
        exp_t x;
        exp_t got;
        bus.en     = e;
        bus.we     = w;
        bus.sel_d  = sd;
        bus.data_d = dd;
        bus.sel_a  = sa;
        bus.sel_b  = sb;
        if (e) begin
            held_a = mdl[sa];
            held_b = mdl[sb];
        end
        x.a = held_a;
        x.b = held_b;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (e && w) mdl[sd] = dd;
        if (sb_q.size() == 0) begin
            chk({tag, "_queue"}, 16'hDEAD, 16'h0000);
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_a"}, bus.data_out_a, got.a);
            chk({tag, "_b"}, bus.data_out_b, got.b);
        end
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must clear without a clock edge.
    task automatic reset_pulse(input string tag);
        bus.en = 1'b0;
        bus.we = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_async_a"}, bus.data_out_a, 16'h0000);
        chk({tag, "_async_b"}, bus.data_out_b, 16'h0000);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b1;
        bus.en = 1'b0; bus.we = 1'b0; bus.data_d = '0;
        bus.sel_a = '0; bus.sel_b = '0; bus.sel_d = '0;
        model_reset();
        @(posedge clk);
        #1;

        reset_pulse("rst");
        for (int i = 0; i < 8; i += 2) begin
            cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(i + 1), "rst_regs");
        end

        cycle(1'b1, 1'b1, 3'd0, 16'hFAB5, 3'd0, 3'd1, "wr_edge1");
        cycle(1'b1, 1'b0, 3'd0, 16'hFAB5, 3'd0, 3'd1, "wr_edge2");

        cycle(1'b1, 1'b0, 3'd0, 16'h1234, 3'd1, 3'd0, "nowe_b");
        cycle(1'b1, 1'b0, 3'd0, 16'h1234, 3'd0, 3'd0, "nowe_r0");

        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 3'd3, 16'hAAAA, 3'd3, 3'd3, "freeze");
        end
        cycle(1'b1, 1'b0, 3'd3, 16'hAAAA, 3'd3, 3'd0, "unfreeze");

        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 3'(i), 16'(16'h1111 * i + 1), 3'(i), 3'(7 - i), "sweep_wr");
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), "sweep_rd");
        end

        cycle(1'b1, 1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd2, "rdw_old");
        cycle(1'b1, 1'b0, 3'd2, 16'h0000, 3'd2, 3'd5, "rdw_new");
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rand");
        end

        reset_pulse("rst2");
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), "rst2_regs");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
